// File: rtl/mux_scan_ctrl.sv
// Scans a 4-to-1 mux select through indices 0..3 and assembles the sampled mux
// output into a 4-bit snapshot. Define MUX_SCAN_CHANGE_EN to add the `changed` flag.
module mux_scan_ctrl #(
  parameter int unsigned STEP_DIV      = 25_000_000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       m_in,
  output logic [1:0] sel,
  output logic [3:0] snapshot,
  output logic       valid,
`ifdef MUX_SCAN_CHANGE_EN
  output logic       busy,
  output logic       changed
`else
  output logic       busy
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       shadow;
  logic             step_end;
  logic             scan_end;

  assign step_end = (state == SCAN) && (cnt == CNT_LAST);
  assign scan_end = step_end && (idx == 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (scan_end && !continuous) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    sel  = idx;
  end

  // Sampling uses the registered cnt, so the sample edge closes the cycle where
  // cnt==SETTLE_CYCLES, well clear of the select change at the step boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      snapshot <= '0;
      valid    <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
      changed  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
      changed <= 1'b0;
`endif
      if (state == SCAN) begin
        if (cnt == CNT_SETTLE) shadow[idx] <= m_in;
        if (step_end) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (scan_end) begin
          snapshot <= shadow;
          valid    <= 1'b1;
`ifdef MUX_SCAN_CHANGE_EN
          changed  <= (shadow != snapshot);
`endif
        end
      end else begin
        cnt <= '0;
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with STEP_DIV=8, SETTLE_CYCLES=2.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       m_in;
  logic [1:0] sel;
  logic [3:0] snapshot;
  logic       valid;
  logic       busy;
`ifdef MUX_SCAN_CHANGE_EN
  logic       changed;
`endif

  logic [3:0] mux_data = '0;
  logic       manual = 1'b0;
  logic       man_val = 1'b0;
  assign m_in = manual ? man_val : mux_data[sel];

  typedef struct packed {
    logic [3:0]  snap;
    logic        chg;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  model_prev = '0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  mux_scan_ctrl #(.STEP_DIV(8), .SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .m_in       (m_in),
    .sel        (sel),
    .snapshot   (snapshot),
    .valid      (valid),
`ifdef MUX_SCAN_CHANGE_EN
    .busy       (busy),
    .changed    (changed)
`else
    .busy       (busy)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] data, input int unsigned at);
    exp_t e;
    e.snap = data;
    e.chg  = (data != model_prev);
    e.cyc  = at;
    model_prev = data;
    sb.push_back(e);
  endtask

  // Call at a negedge; returns the cycle count seen just after the accepting edge.
  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic do_scan(input logic [3:0] data, input bit push, output int unsigned c0);
    @(negedge clock);
    mux_data = data;
    start = 1'b1;
    c0 = cyc + 1;
    if (push) push_exp(data, c0 + 32);
    @(negedge clock);
    start = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(snapshot), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("snapshot", 32'(snapshot), 32'(e.snap));
        chk("valid_cycle", cyc, e.cyc);
`ifdef MUX_SCAN_CHANGE_EN
        chk("changed", 32'(changed), 32'(e.chg));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    logic [3:0] t;

    repeat (3) @(negedge clock);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_snapshot", 32'(snapshot), 0);
    chk("rst_valid", 32'(valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: single scan, u,v,w,x = 1,0,1,1
    do_scan(4'b1101, 1'b1, c0);
    for (int k = 0; k < 4; k++) begin
      wait_until(c0 + 8*k);
      chk("sel_step_start", 32'(sel), 32'(k));
      wait_until(c0 + 8*k + 7);
      chk("sel_step_end", 32'(sel), 32'(k));
    end
    chk("busy_in_scan", 32'(busy), 1);
    wait_until(c0 + 32);
    chk("busy_after_scan", 32'(busy), 0);
    chk("sel_after_scan", 32'(sel), 0);

    // 4: start re-pulsed mid-scan is ignored
    do_scan(4'b1011, 1'b1, c0);
    wait_until(c0 + 4);
    start = 1'b1;
    wait_until(c0 + 5);
    start = 1'b0;
    wait_until(c0 + 33);
    chk("busy_after_ignored_start", 32'(busy), 0);
    repeat (4) @(negedge clock);

    // 5: m_in glitches during cnt 0..1, settles for cnt 2..7
    t = 4'b0101;
    manual = 1'b1;
    man_val = ~t[0];
    do_scan(t, 1'b1, c0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) begin
        wait_until(c0 + 8*k + j);
        man_val = (j < 2) ? ~t[k] : t[k];
      end
    wait_until(c0 + 33);
    manual = 1'b0;

    // 2: continuous scanning, third scan ends after continuous drops
    continuous = 1'b1;
    do_scan(4'b0110, 1'b1, c0);
    push_exp(4'b0110, c0 + 64);
    push_exp(4'b0110, c0 + 96);
    wait_until(c0 + 33);
    chk("busy_continuous_1", 32'(busy), 1);
    wait_until(c0 + 65);
    chk("busy_continuous_2", 32'(busy), 1);
    wait_until(c0 + 70);
    continuous = 1'b0;
    wait_until(c0 + 97);
    chk("busy_after_continuous", 32'(busy), 0);

    // 3: async reset mid-scan discards the partial result
    do_scan(4'b1111, 1'b0, c0);
    wait_until(c0 + 13);
    reset = 1'b1;
    #1;
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_snapshot", 32'(snapshot), 0);
    chk("midrst_valid", 32'(valid), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_prev = '0;
    wait_until(cyc + 40);
    chk("busy_after_midrst", 32'(busy), 0);

    // 6: change detection sequence
    do_scan(4'b1101, 1'b1, c0);
    wait_until(c0 + 33);
    do_scan(4'b1101, 1'b1, c0);
    wait_until(c0 + 33);
    do_scan(4'b0001, 1'b1, c0);
    wait_until(c0 + 33);
    chk("snapshot_holds", 32'(snapshot), 32'h1);

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
